// File: rtl/spi_adc_master_if.sv
// SPI pin bundle between the FPGA-side initiator and an MCP3002-style ADC.
interface spi_adc_master_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    input  miso
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    output miso
  );
endinterface

// File: rtl/spi_adc_master.sv
// Periodic SPI reader for an MCP3002-style 10-bit ADC.
// Each period tick seen while idle runs one 16-bit mode-0 frame:
//   SETUP (D clk), 32 SCLK half-periods of D clk, HOLD (D clk), DONE (1 clk).
// The 10-bit result is presented on sample with a one-cycle sample_valid.
module spi_adc_master #(
  parameter int CLK_DIV       = 20,
  parameter int SAMPLE_PERIOD = 40000,
  parameter int FRAME_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    channel,
  spi_adc_master_if.master        spi,
  output logic [9:0]              sample,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  // Period counter
  logic [PW-1:0] period_d, period_q;
  logic          tick;

  // Frame sequencer state
  state_t        state_q;
  logic [HW-1:0] hc_q;
  logic [3:0]    bit_q;
  logic [15:0]   cmd_q;
  logic [9:0]    rx_q;
  logic          sclk_q;
  logic          cs_n_q;
  logic          mosi_q;
  logic [9:0]    sample_q;
  logic          sample_valid_q;
  logic          busy_q;
  logic          overrun_q;
  logic          last_half;

  assign last_half = (hc_q == HW'(CLK_DIV - 1));

  // Next period count and the tick that fires on the last count of each period.
  always_comb begin
    tick     = 1'b0;
    period_d = period_q;
    if (!enable) begin
      period_d = '0;
    end else if (period_q == PW'(SAMPLE_PERIOD - 1)) begin
      tick     = 1'b1;
      period_d = '0;
    end else begin
      period_d = period_q + 1'b1;
    end
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  // Frame FSM; every pin and status output is a flop so SCLK/CS/MOSI are glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hc_q           <= '0;
      bit_q          <= '0;
      cmd_q          <= '0;
      rx_q           <= '0;
      sclk_q         <= 1'b0;
      cs_n_q         <= 1'b1;
      mosi_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      // A tick during an active frame is dropped, not queued.
      if (tick && busy_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= SETUP;
            cmd_q   <= {1'b1, 1'b1, channel, 1'b1, 12'b0};
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            hc_q    <= '0;
          end
        end
        SETUP: begin
          if (last_half) begin
            // First SCLK rise; bit 15 falls in the command window and is not kept.
            state_q <= SHIFT;
            hc_q    <= '0;
            sclk_q  <= 1'b1;
            bit_q   <= 4'(FRAME_BITS - 1);
          end else begin
            hc_q <= hc_q + 1'b1;
          end
        end
        SHIFT: begin
          if (!last_half) begin
            hc_q <= hc_q + 1'b1;
          end else begin
            hc_q <= '0;
            if (sclk_q) begin
              // Falling edge: present the next command bit (zero after the last).
              sclk_q <= 1'b0;
              mosi_q <= cmd_q[14];
              cmd_q  <= {cmd_q[14:0], 1'b0};
            end else if (bit_q == 4'd0) begin
              state_q <= HOLD;
            end else begin
              // Rising edge for bit (bit_q-1); only data bits 10..1 are captured.
              sclk_q <= 1'b1;
              bit_q  <= bit_q - 4'd1;
              if (bit_q >= 4'd2 && bit_q <= 4'd11) begin
                rx_q <= {rx_q[8:0], spi.miso};
              end
            end
          end
        end
        HOLD: begin
          if (last_half) begin
            state_q        <= DONE;
            cs_n_q         <= 1'b1;
            busy_q         <= 1'b0;
            mosi_q         <= 1'b0;
            sample_q       <= rx_q;
            sample_valid_q <= 1'b1;
          end else begin
            hc_q <= hc_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign spi.sclk     = sclk_q;
  assign spi.cs_n     = cs_n_q;
  assign spi.mosi     = mosi_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
